// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the CPU data-memory port. Accepts one word-
//   addressed load/store at a time over a valid/ready request channel,
//   inserts WAIT_CYCLES wait states, then presents the result on a
//   valid/ready response channel until the requester takes it.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-low
//   req_valid   request present
//   req_ready   high only in IDLE
//   req_we      1 = store, 0 = load
//   req_addr    word address (ISIZE bits)
//   req_wdata   store data (DSIZE bits)
//   req_be      byte-lane write enables (only with DMEM_BYTE_STROBE_EN)
//   resp_valid  response present
//   resp_ready  requester takes the response
//   resp_rdata  load data; 0 for stores, errors and when resp_valid=0
//   resp_err    address was out of range
//   busy        high in any state other than IDLE
//
// Build option
//   DMEM_BYTE_STROBE_EN  adds req_be; stores write only enabled byte lanes.
//                        Without it every store writes the full word.
module dmem_responder #(
  parameter int DSIZE       = 32,
  parameter int ISIZE       = 32,
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ISIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [DSIZE/8-1:0] req_be,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [DSIZE-1:0] resp_rdata,
  output logic             resp_err,
  output logic             busy
);

  localparam int NLANE = DSIZE / 8;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [3:0]       cnt;
  logic             accept;
  logic             commit;

  logic             we_q;
  logic [ISIZE-1:0] addr_q;
  logic [DSIZE-1:0] wdata_q;
  logic [NLANE-1:0] be_q;

  logic             c_we;
  logic [ISIZE-1:0] c_addr;
  logic [DSIZE-1:0] c_wdata;
  logic [NLANE-1:0] c_be;
  logic [NLANE-1:0] live_be;
  logic             in_range;
  logic [AW-1:0]    idx;

  logic [DSIZE-1:0] rdata_q;
  logic             err_q;

  logic [DSIZE-1:0] mem [DEPTH] = '{default: '0};

`ifdef DMEM_BYTE_STROBE_EN
  assign live_be = req_be;
`else
  assign live_be = '1;
`endif

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the accept edge itself, so
  // the request is taken straight from the ports instead of the capture regs.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    c_be    = be_q;
    if (state == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = live_be;
    end
  end

  assign in_range = (c_addr[ISIZE-1:AW] == '0);
  assign idx      = c_addr[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q   <= !in_range;
        rdata_q <= (in_range && !c_we) ? mem[idx] : '0;
      end else if ((state == S_RESP) && resp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Request capture: data path only, reset not needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= live_be;
    end
  end

  // Storage write; a reset during WAIT removes the commit, so the store is dropped.
  always_ff @(posedge clk) begin
    if (commit && c_we && in_range) begin
      for (int i = 0; i < NLANE; i++) begin
        if (c_be[i]) mem[idx][i*8 +: 8] <= c_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Directed bench for dmem_responder. Instance u_a uses WAIT_CYCLES=2,
//   instance u_b uses WAIT_CYCLES=0. Inputs change and outputs are sampled
//   on the falling edge.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  a_req_be, b_req_be;
`endif

  int n_checks;
  int n_fail;
  int lat;

  dmem_responder #(.DSIZE(32), .ISIZE(32), .DEPTH(256), .AW(8), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(a_req_be),
`endif
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.DSIZE(32), .ISIZE(32), .DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(b_req_be),
`endif
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request to u_a and return on the falling edge after it is accepted.
  // The request inputs are scrambled afterwards so only captured values matter.
  task automatic send_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    int n;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
`ifdef DMEM_BYTE_STROBE_EN
    a_req_be    = be;
`else
    if (be == 4'hx) n = 0;
`endif
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_val("accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_we    = ~we;
    a_req_addr  = 32'hFFFF_FFF0;
    a_req_wdata = 32'h5A5A_A5A5;
`ifdef DMEM_BYTE_STROBE_EN
    a_req_be    = 4'h0;
`endif
  endtask

  // Count falling edges from the first cycle after accept until resp_valid.
  task automatic wait_resp_a(output int l);
    l = 1;
    while (!a_resp_valid && l < 40) begin
      @(negedge clk);
      l++;
    end
    if (l >= 40) check_val("resp_timeout", 64'd1, 64'd0);
  endtask

  // Full transaction on u_a with resp_ready=1; checks latency, data and error.
  task automatic xact_a(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int l;
    send_a(we, addr, wdata, be);
    wait_resp_a(l);
    check_val({tag, "_lat"}, 64'(l), 64'd3);
    check_val({tag, "_rdata"}, 64'(a_resp_rdata), 64'(exp_rdata));
    check_val({tag, "_err"}, 64'(a_resp_err), 64'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
    a_req_be = 4'hF;
    b_req_be = 4'hF;
`endif
    @(negedge clk);
    @(negedge clk);
    check_val("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    check_val("rst_rdata", 64'(a_resp_rdata), 64'd0);
    check_val("rst_err", 64'(a_resp_err), 64'd0);
    check_val("rst_busy", 64'(a_busy), 64'd0);
    check_val("rst_req_ready", 64'(a_req_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    // Store then load, WAIT_CYCLES=2
    xact_a("st5", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact_a("ld5", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Zero wait states on u_b
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'd0;
    check_val("b_ready_idle", 64'(b_req_ready), 64'd1);
    @(negedge clk);
    b_req_valid = 1'b0;
    check_val("b_resp_valid", 64'(b_resp_valid), 64'd1);
    check_val("b_req_ready_resp", 64'(b_req_ready), 64'd0);
    check_val("b_rdata0", 64'(b_resp_rdata), 64'd0);
    check_val("b_err0", 64'(b_resp_err), 64'd0);
    b_resp_ready = 1'b1;
    @(negedge clk);
    check_val("b_resp_done", 64'(b_resp_valid), 64'd0);
    check_val("b_ready_back", 64'(b_req_ready), 64'd1);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'd4; b_req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    b_req_valid = 1'b0;
    check_val("b_st_valid", 64'(b_resp_valid), 64'd1);
    check_val("b_st_rdata", 64'(b_resp_rdata), 64'd0);
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'd4;
    @(negedge clk);
    b_req_valid = 1'b0;
    check_val("b_ld_valid", 64'(b_resp_valid), 64'd1);
    check_val("b_ld_rdata", 64'(b_resp_rdata), 64'hCAFEF00D);
    @(negedge clk);

    // Out of range
    xact_a("ld256", 1'b0, 32'd256, 32'h0, 4'hF, 32'h0, 1'b1);
    xact_a("st261", 1'b1, 32'd261, 32'h0BAD0BAD, 4'hF, 32'h0, 1'b1);
    xact_a("ld0", 1'b0, 32'd0, 32'h0, 4'hF, 32'h0, 1'b0);
    xact_a("ld5b", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Response held off while a new request waits
    a_resp_ready = 1'b0;
    send_a(1'b0, 32'd5, 32'h0, 4'hF);
    wait_resp_a(lat);
    check_val("hold_lat", 64'(lat), 64'd3);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'd9; a_req_wdata = 32'h12345678;
`ifdef DMEM_BYTE_STROBE_EN
    a_req_be = 4'hF;
`endif
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", 64'(a_resp_valid), 64'd1);
      check_val("hold_rdata", 64'(a_resp_rdata), 64'hDEADBEEF);
      check_val("hold_busy", 64'(a_busy), 64'd1);
      check_val("hold_ready", 64'(a_req_ready), 64'd0);
      @(negedge clk);
    end
    a_resp_ready = 1'b1;
    @(negedge clk);
    check_val("rel_valid", 64'(a_resp_valid), 64'd0);
    check_val("rel_ready", 64'(a_req_ready), 64'd1);
    check_val("rel_rdata", 64'(a_resp_rdata), 64'd0);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_req_addr  = 32'hFFFF_FFF0;
    check_val("pend_busy", 64'(a_busy), 64'd1);
    wait_resp_a(lat);
    check_val("pend_lat", 64'(lat), 64'd3);
    check_val("pend_err", 64'(a_resp_err), 64'd0);
    @(negedge clk);
    xact_a("ld9", 1'b0, 32'd9, 32'h0, 4'hF, 32'h12345678, 1'b0);

    // Reset during WAIT drops the store
    xact_a("st7", 1'b1, 32'd7, 32'h11111111, 4'hF, 32'h0, 1'b0);
    send_a(1'b1, 32'd7, 32'h22222222, 4'hF);
    check_val("wait_busy", 64'(a_busy), 64'd1);
    rst = 1'b0;
    #1;
    check_val("abort_busy", 64'(a_busy), 64'd0);
    check_val("abort_ready", 64'(a_req_ready), 64'd1);
    check_val("abort_valid", 64'(a_resp_valid), 64'd0);
    check_val("abort_rdata", 64'(a_resp_rdata), 64'd0);
    check_val("abort_err", 64'(a_resp_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact_a("ld7", 1'b0, 32'd7, 32'h0, 4'hF, 32'h11111111, 1'b0);

    // Byte lanes
`ifdef DMEM_BYTE_STROBE_EN
    xact_a("be_full", 1'b1, 32'd3, 32'hAABBCCDD, 4'b1111, 32'h0, 1'b0);
    xact_a("be_lane0", 1'b1, 32'd3, 32'h00000011, 4'b0001, 32'h0, 1'b0);
    xact_a("be_ld", 1'b0, 32'd3, 32'h0, 4'hF, 32'hAABBCC11, 1'b0);
    xact_a("be_none", 1'b1, 32'd3, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    xact_a("be_ld2", 1'b0, 32'd3, 32'h0, 4'hF, 32'hAABBCC11, 1'b0);
    xact_a("be_hi", 1'b1, 32'd3, 32'h99000000, 4'b1000, 32'h0, 1'b0);
    xact_a("be_ld3", 1'b0, 32'd3, 32'h0, 4'hF, 32'h99BBCC11, 1'b0);
`else
    xact_a("w_full", 1'b1, 32'd3, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0);
    xact_a("w_over", 1'b1, 32'd3, 32'h00000011, 4'hF, 32'h0, 1'b0);
    xact_a("w_ld", 1'b0, 32'd3, 32'h0, 4'hF, 32'h00000011, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
